// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display controller: segment codes,
// FSM state type and digit-count helpers.
package seg_pkg;

  // Active-low segment patterns, bit order gfedcba.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_T     = 7'b0000111;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SHOW,
    HALTED
  } state_e;

  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    case (digit)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Decimal digits needed for the largest w-bit value: floor(w*log10(2)) + 1,
  // e.g. 10 for 32 bits (4294967295).
  function automatic int BCD_DIGITS(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter: DATA_W shift cycles per
// conversion, done held for one cycle after the last shift.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BCD_N  = BCD_DIGITS(DATA_W)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DATA_W-1:0]    din,
  output logic                 done,
  output logic [4*BCD_N-1:0]   bcd
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]  bin_q;
  logic [4*BCD_N-1:0] bcd_q;
  logic [4*BCD_N-1:0] adj;
  logic [CNT_W-1:0]   cnt_q;
  logic               run_q;
  logic               adj_msb_unused;

  // NOTE: every variable written in always_comb gets a value before any
  // conditional code, otherwise synthesis infers a latch to hold it.
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < BCD_N; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // The top nibble never reaches 8 when BCD_N is sized correctly.
  assign adj_msb_unused = adj[4*BCD_N-1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      bin_q <= '0;
      bcd_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= CNT_W'(DATA_W);
      bin_q <= din;
      bcd_q <= '0;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        bcd_q <= {adj[4*BCD_N-2:0], bin_q[DATA_W-1]};
        bin_q <= {bin_q[DATA_W-2:0], 1'b0};
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        run_q <= 1'b0;
      end
    end
  end

  assign done = run_q && (cnt_q == '0);
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// Seven-segment display controller: request FSM, sign/overflow/blanking
// formatting of the BCD result and the registered segment outputs.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int DATA_W   = 32,
  parameter int IN_W     = 4,
  parameter int SIGNED   = 0,
  parameter int LZ_BLANK = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  halt,
  input  logic                  out_valid,
  input  logic                  in_req,
  input  logic [DATA_W-1:0]     num,
  input  logic [15:0]           SW,
  output logic [DATA_W-1:0]     user_input,
  output logic                  busy,
  output logic [7*N_DIGITS-1:0] hex
);

  localparam int BCD_N = BCD_DIGITS(DATA_W);
  localparam int PAD_D = (N_DIGITS > BCD_N) ? N_DIGITS : BCD_N;

  state_e                state_q, state_d;
  logic [7*N_DIGITS-1:0] hex_q, hex_d;
  logic                  neg_q, neg_d;
  logic                  start, done;
  logic [4*BCD_N-1:0]    bcd;
  logic [4*PAD_D-1:0]    bcd_pad;
  logic [DATA_W-1:0]     operand;
  logic [DATA_W:0]       op_ext, op_mag;
  logic                  op_neg;
  logic                  mag_msb_unused;
  logic                  sw_unused;
  logic [7*N_DIGITS-1:0] result_hex, banner_hex, dash_hex;

  assign user_input = DATA_W'(SW[IN_W-1:0]);
  assign sw_unused  = ^SW;

  // Magnitude is formed one bit wider so the most negative value negates exactly.
  assign operand = in_req ? user_input : num;
  assign op_neg  = (SIGNED != 0) && operand[DATA_W-1];
  assign op_ext  = {op_neg, operand};
  assign op_mag  = op_neg ? (~op_ext + (DATA_W+1)'(1)) : op_ext;
  assign mag_msb_unused = op_mag[DATA_W];

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .BCD_N  (BCD_N)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .abort (halt),
    .din   (op_mag[DATA_W-1:0]),
    .done  (done),
    .bcd   (bcd)
  );

  assign bcd_pad  = (4*PAD_D)'(bcd);
  assign dash_hex = {N_DIGITS{SEG_DASH}};

  always_comb begin
    banner_hex = dash_hex;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (k == 3)      banner_hex[7*k +: 7] = SEG_H;
      else if (k == 2) banner_hex[7*k +: 7] = SEG_A;
      else if (k == 1) banner_hex[7*k +: 7] = SEG_L;
      else if (k == 0) banner_hex[7*k +: 7] = SEG_T;
    end
  end

  // Format the finished conversion: a negative sign claims the top digit, so
  // one fewer digit is available before the value counts as overflow.
  always_comb begin
    logic       ovf;
    logic       blank_run;
    logic [3:0] nib;
    int         avail;
    ovf        = 1'b0;
    blank_run  = (LZ_BLANK != 0);
    nib        = '0;
    avail      = neg_q ? N_DIGITS - 1 : N_DIGITS;
    result_hex = {N_DIGITS{SEG_BLANK}};
    for (int k = 0; k < PAD_D; k++) begin
      if (k >= avail && bcd_pad[4*k +: 4] != 4'd0) ovf = 1'b1;
    end
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      nib = bcd_pad[4*k +: 4];
      if (neg_q && k == N_DIGITS - 1) begin
        result_hex[7*k +: 7] = SEG_DASH;
      end else if (nib != 4'd0) begin
        result_hex[7*k +: 7] = seg_of(nib);
        blank_run = 1'b0;
      end else if (blank_run && k != 0) begin
        result_hex[7*k +: 7] = SEG_BLANK;
      end else begin
        result_hex[7*k +: 7] = seg_of(nib);
      end
    end
    if (ovf) result_hex = {N_DIGITS{SEG_E}};
  end

  always_comb begin
    state_d = state_q;
    hex_d   = hex_q;
    neg_d   = neg_q;
    start   = 1'b0;
    if (halt) begin
      state_d = HALTED;
      hex_d   = banner_hex;
    end else begin
      case (state_q)
        IDLE, SHOW: begin
          if (out_valid != in_req) begin
            if (in_req && user_input == '0) begin
              hex_d   = dash_hex;
              state_d = SHOW;
            end else begin
              start   = 1'b1;
              neg_d   = op_neg;
              state_d = CONV;
            end
          end else if (!out_valid && state_q == IDLE) begin
            hex_d = dash_hex;
          end
        end
        CONV: begin
          if (done) begin
            hex_d   = result_hex;
            state_d = SHOW;
          end
        end
        HALTED:  hex_d = banner_hex;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hex_q   <= {N_DIGITS{SEG_BLANK}};
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hex_q   <= hex_d;
      neg_q   <= neg_d;
    end
  end

  assign busy = (state_q == CONV);
  assign hex  = hex_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Randomized self-checking bench for seg_display_ctrl: an unsigned instance and
// a signed, zero-blanking instance checked against a decimal reference model.
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        reset, halt, out_valid, in_req;
  logic [31:0] num;
  logic [15:0] SW;
  logic [31:0] user_input_a, user_input_b;
  logic        busy_a, busy_b;
  logic [55:0] hex_a, hex_b;

  int checks = 0;
  int errors = 0;
  logic [55:0] exp_a, exp_b;

  localparam logic [6:0]  DASH = 7'h3F;
  localparam logic [55:0] ALL_BLANK = {8{7'h7F}};
  localparam logic [55:0] ALL_DASH  = {8{7'h3F}};
  localparam logic [55:0] BANNER    = {DASH, DASH, DASH, DASH,
                                       7'h09, 7'h08, 7'h47, 7'h07};

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  seg_display_ctrl dut_a (
    .clk(clk), .reset(reset), .halt(halt), .out_valid(out_valid),
    .in_req(in_req), .num(num), .SW(SW), .user_input(user_input_a),
    .busy(busy_a), .hex(hex_a)
  );

  seg_display_ctrl #(.SIGNED(1), .LZ_BLANK(1)) dut_b (
    .clk(clk), .reset(reset), .halt(halt), .out_valid(out_valid),
    .in_req(in_req), .num(num), .SW(SW), .user_input(user_input_b),
    .busy(busy_b), .hex(hex_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decimal reference: what an 8-digit display should show for value v.
  function automatic logic [55:0] model(input logic [31:0] v, input bit sgn, input bit lzb);
    logic [55:0] r;
    longint m, limit;
    int d [8];
    int avail, msd;
    bit neg;
    neg = sgn && v[31];
    m = longint'(v);
    if (neg) m = 64'd4294967296 - m;
    avail = neg ? 7 : 8;
    limit = 1;
    for (int i = 0; i < avail; i++) limit = limit * 10;
    if (m >= limit) return {8{7'h06}};
    for (int k = 0; k < 8; k++) begin
      d[k] = int'(m % 10);
      m = m / 10;
    end
    msd = 0;
    for (int k = 0; k < 8; k++) if (d[k] != 0) msd = k;
    for (int k = 0; k < 8; k++) begin
      if (neg && k == 7)               r[7*k +: 7] = DASH;
      else if (lzb && k > msd && k != 0) r[7*k +: 7] = 7'h7F;
      else                             r[7*k +: 7] = seg_tab[d[k]];
    end
    return r;
  endfunction

  // Waits for busy to fall; optionally injects a request that must be ignored.
  task automatic wait_done(input bit inject, output int cycles);
    cycles = 0;
    while (busy_a === 1'b1 && cycles < 100) begin
      if (inject && cycles == 4) begin
        out_valid = 1'b1;
        num = $urandom;
      end
      if (inject && cycles == 5) out_valid = 1'b0;
      if (cycles == 10) begin
        check("hold_a", hex_a, exp_a);
        check("hold_b", hex_b, exp_b);
      end
      step();
      cycles++;
    end
  endtask

  task automatic display(input logic [31:0] v);
    int cyc;
    num = v;
    out_valid = 1'b1;
    step();
    out_valid = 1'b0;
    check("busy_start", {busy_b, busy_a}, 2'b11);
    wait_done(1'b1, cyc);
    check("latency", cyc, 33);
    check("busy_end_b", busy_b, 1'b0);
    exp_a = model(v, 1'b0, 1'b0);
    exp_b = model(v, 1'b1, 1'b1);
    check("hex_a", hex_a, exp_a);
    check("hex_b", hex_b, exp_b);
  endtask

  logic [31:0] directed [9] = '{32'd12345678, 32'd100000000, 32'hFFFFFFD6,
                                32'd0, 32'h80000000, 32'd99999999,
                                32'hFFFFFFFF, 32'hFF676981, 32'd10000000};

  initial begin
    int cyc;
    reset = 1'b1; halt = 1'b0; out_valid = 1'b0; in_req = 1'b0;
    num = '0; SW = '0;
    step();
    step();
    check("reset_hex_a", hex_a, ALL_BLANK);
    check("reset_hex_b", hex_b, ALL_BLANK);
    check("reset_busy", {busy_b, busy_a}, 2'b00);
    reset = 1'b0;
    step();
    check("idle_dash_a", hex_a, ALL_DASH);
    check("idle_dash_b", hex_b, ALL_DASH);
    exp_a = ALL_DASH;
    exp_b = ALL_DASH;

    // Simultaneous out_valid and in_req is illegal and must be ignored.
    out_valid = 1'b1; in_req = 1'b1; num = 32'd5; SW = 16'h0003;
    step();
    check("illegal_busy", {busy_b, busy_a}, 2'b00);
    check("illegal_hex_a", hex_a, exp_a);
    out_valid = 1'b0; in_req = 1'b0;
    step();

    foreach (directed[i]) display(directed[i]);

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0:       display($urandom);
        1:       display(32'($urandom_range(0, 99999999)));
        2:       display(32'd0 - 32'($urandom_range(1, 9999999)));
        default: display(32'($urandom_range(0, 999)));
      endcase
    end

    // Switch input path, including a zero value that bypasses conversion.
    SW = 16'h0009; in_req = 1'b1;
    #1;
    check("user_input_9", user_input_a, 32'd9);
    step();
    check("in_busy", busy_a, 1'b1);
    wait_done(1'b0, cyc);
    check("in_latency", cyc, 33);
    exp_a = model(32'd9, 1'b0, 1'b0);
    exp_b = model(32'd9, 1'b1, 1'b1);
    check("in_hex_a", hex_a, exp_a);
    check("in_hex_b", hex_b, exp_b);
    SW = 16'h0000;
    #1;
    check("user_input_0", user_input_b, 32'd0);
    step();
    check("zero_dash_a", hex_a, ALL_DASH);
    check("zero_dash_b", hex_b, ALL_DASH);
    check("zero_busy", {busy_b, busy_a}, 2'b00);
    in_req = 1'b0;
    SW = 16'hFFF5;
    #1;
    check("user_input_5", user_input_a, 32'd5);
    step();
    check("show_hold", hex_a, ALL_DASH);

    // Halt during a conversion aborts it and locks the banner in.
    num = 32'd12345678; out_valid = 1'b1;
    step();
    out_valid = 1'b0;
    repeat (5) step();
    halt = 1'b1;
    step();
    check("halt_busy", {busy_b, busy_a}, 2'b00);
    check("halt_hex_a", hex_a, BANNER);
    check("halt_hex_b", hex_b, BANNER);
    halt = 1'b0; out_valid = 1'b1; num = 32'd7;
    step();
    out_valid = 1'b0; in_req = 1'b1;
    step();
    in_req = 1'b0;
    check("halted_busy", {busy_b, busy_a}, 2'b00);
    check("halted_hex", hex_a, BANNER);

    reset = 1'b1;
    step();
    reset = 1'b0;
    check("unhalt_hex", hex_a, ALL_BLANK);

    // Halt beats a request on the same edge; reset beats halt.
    out_valid = 1'b1; num = 32'd42; halt = 1'b1;
    step();
    out_valid = 1'b0;
    check("halt_vs_req_busy", busy_a, 1'b0);
    check("halt_vs_req_hex", hex_b, BANNER);
    reset = 1'b1;
    step();
    check("reset_vs_halt_hex", hex_a, ALL_BLANK);
    check("reset_vs_halt_busy", busy_a, 1'b0);
    reset = 1'b0; halt = 1'b0;
    step();
    check("final_idle_dash", hex_a, ALL_DASH);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
